// File: rtl/usb_cdc_tx_arbiter.sv
// Round-robin, burst-locking arbiter feeding the usb_cdc_core inport byte stream (clk_usb domain).
// Optional per-requester byte statistics are built when USB_ARB_STATS_EN is defined.
module usb_cdc_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 16,
  parameter int IDLE_CYCLES = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_accept_o,
  output logic                   inport_valid_o,
  output logic [7:0]             inport_data_o,
  input  logic                   inport_accept_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o
`ifdef USB_ARB_STATS_EN
  ,
  input  logic [2:0]             stat_sel_i,
  output logic [15:0]            stat_count_o
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {S_IDLE, S_GRANT} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [7:0]           byte_cnt_q, byte_cnt_d;
  logic [7:0]           idle_cnt_q, idle_cnt_d;
  logic                 busy_q, busy_d;

  logic [IDX_W-1:0]     gidx;
  logic                 gvalid;
  logic                 glast;
  logic                 handshake;
  logic                 found;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     cand;
  logic [7:0]           byte_inc;
  logic [7:0]           idle_inc;
  logic                 release_grant;

  // Granted index and the combinational datapath through the registered grant
  always_comb begin
    gidx = '0;
    inport_data_o = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) gidx = IDX_W'(i);
      inport_data_o = inport_data_o | (req_data_i[8*i +: 8] & {8{grant_q[i]}});
    end
  end

  assign gvalid         = req_valid_i[gidx];
  assign glast          = req_last_i[gidx];
  assign inport_valid_o = |(grant_q & req_valid_i);
  assign handshake      = inport_valid_o & inport_accept_i;
  assign req_accept_o   = grant_q & {NUM_REQ{inport_accept_i}};
  assign grant_o        = grant_q;
  assign busy_o         = busy_q;

  assign byte_inc = byte_cnt_q + 8'd1;
  assign idle_inc = (idle_cnt_q == 8'hFF) ? 8'hFF : idle_cnt_q + 8'd1;

  always_comb begin
    found    = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(rr_q) + i) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        found    = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    byte_cnt_d    = byte_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    busy_d        = busy_q;
    release_grant = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d    = NUM_REQ'(1) << pick_idx;
          state_d    = S_GRANT;
          busy_d     = 1'b1;
          byte_cnt_d = 8'd0;
          idle_cnt_d = 8'd0;
        end
      end
      S_GRANT: begin
        if (handshake) begin
          byte_cnt_d    = byte_inc;
          idle_cnt_d    = 8'd0;
          release_grant = glast || (byte_inc == 8'(MAX_BURST));
        end else if (!gvalid) begin
          idle_cnt_d    = idle_inc;
          release_grant = (idle_inc == 8'(IDLE_CYCLES));
        end else begin
          // Valid held but stalled by the core: not idle, so the count restarts
          idle_cnt_d = 8'd0;
        end
        if (release_grant) begin
          grant_d = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
          rr_d    = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      byte_cnt_q <= 8'd0;
      idle_cnt_q <= 8'd0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      byte_cnt_q <= byte_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      busy_q     <= busy_d;
    end
  end

`ifdef USB_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];
  logic [15:0] stat_count_q, stat_count_d;

  always_comb begin
    cnt_d = cnt_q;
    if (handshake && (cnt_q[gidx] != 16'hFFFF)) cnt_d[gidx] = cnt_q[gidx] + 16'd1;
    stat_count_d = 16'h0000;
    if (int'(stat_sel_i) < NUM_REQ) stat_count_d = cnt_q[stat_sel_i[IDX_W-1:0]];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= 16'h0000;
      stat_count_q <= 16'h0000;
    end else begin
      cnt_q        <= cnt_d;
      stat_count_q <= stat_count_d;
    end
  end

  assign stat_count_o = stat_count_q;
`endif

endmodule

// File: tb/tb_usb_cdc_tx_arbiter.sv
// Bench for usb_cdc_tx_arbiter: directed scenarios plus randomized traffic against a rule-level model.
module tb_usb_cdc_tx_arbiter;
  localparam int N  = 4;
  localparam int MB = 16;
  localparam int IC = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_accept;
  logic           inport_valid;
  logic [7:0]     inport_data;
  logic           inport_accept;
  logic [N-1:0]   grant;
  logic           busy;
`ifdef USB_ARB_STATS_EN
  logic [2:0]     stat_sel;
  logic [15:0]    stat_count;
`endif

  always #5 clk = ~clk;

  usb_cdc_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .IDLE_CYCLES(IC)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_accept_o(req_accept),
    .inport_valid_o(inport_valid), .inport_data_o(inport_data), .inport_accept_i(inport_accept),
    .grant_o(grant), .busy_o(busy)
`ifdef USB_ARB_STATS_EN
    , .stat_sel_i(stat_sel), .stat_count_o(stat_count)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Producer queues: bit 8 is the last flag
  logic [8:0] pm [N][256];
  int ph [N];
  int pt [N];
  bit hold [N];
  int gap_pct = 0;
  int acc_pct = 100;

  // Reference model state: granted index (-1 idle), rr pointer, burst and idle counts
  int mg = -1, mrr = 0, mbc = 0, mic = 0;
  int mcnt [N];

  int log_req [$];
  int log_dat [$];
  int log_cyc [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int n, input int d, input bit l);
    pm[n][pt[n] % 256] = {l, 8'(d)};
    pt[n]++;
  endtask

  task automatic flush();
    for (int n = 0; n < N; n++) begin
      ph[n] = pt[n];
      hold[n] = 1'b0;
    end
  endtask

  task automatic step();
    logic [N-1:0] eg;
    logic ev;
    logic [7:0] ed;
    bit hs, rel, found, en;
    int k;
    for (int n = 0; n < N; n++) begin
      en = hold[n] || ($urandom_range(99) >= gap_pct);
      if (ph[n] < pt[n] && en) begin
        req_valid[n] = 1'b1;
        req_data[8*n +: 8] = pm[n][ph[n] % 256][7:0];
        req_last[n] = pm[n][ph[n] % 256][8];
      end else begin
        req_valid[n] = 1'b0;
        req_data[8*n +: 8] = 8'($urandom);
        req_last[n] = 1'($urandom_range(1));
      end
    end
    inport_accept = ($urandom_range(99) < acc_pct);
    @(negedge clk);
    eg = (mg >= 0) ? (N'(1) << mg) : '0;
    ev = (mg >= 0) && req_valid[mg];
    ed = (mg >= 0) ? req_data[8*mg +: 8] : 8'h00;
    chk("grant", 32'(grant), 32'(eg));
    chk("inport_valid", 32'(inport_valid), 32'(ev));
    chk("inport_data", 32'(inport_data), 32'(ed));
    chk("req_accept", 32'(req_accept), 32'(eg & {N{inport_accept}}));
    chk("busy", 32'(busy), 32'(mg >= 0));
    hs = ev && inport_accept;
    if (hs) begin
      log_req.push_back(mg);
      log_dat.push_back(int'(ed));
      log_cyc.push_back(cyc);
      ph[mg]++;
      if (mcnt[mg] < 65535) mcnt[mg]++;
    end
    for (int n = 0; n < N; n++) hold[n] = req_valid[n] && !(eg[n] && inport_accept);
    if (rst) begin
      mg = -1; mrr = 0; mbc = 0; mic = 0;
      for (int n = 0; n < N; n++) mcnt[n] = 0;
    end else if (mg < 0) begin
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
        k = (mrr + i) % N;
        if (!found && req_valid[k]) begin
          found = 1'b1;
          mg = k;
        end
      end
      mbc = 0;
      mic = 0;
    end else begin
      rel = 1'b0;
      if (hs) begin
        mbc++;
        mic = 0;
        rel = req_last[mg] || (mbc == MB);
      end else if (!req_valid[mg]) begin
        if (mic < 255) mic++;
        rel = (mic >= IC);
      end else begin
        mic = 0;
      end
      if (rel) begin
        mrr = (mg + 1) % N;
        mg = -1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int b, c0, pushed;
    int ord [5];
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_last = '0;
    inport_accept = 1'b0;
`ifdef USB_ARB_STATS_EN
    stat_sel = 3'd0;
`endif
    for (int n = 0; n < N; n++) begin
      ph[n] = 0; pt[n] = 0; hold[n] = 1'b0; mcnt[n] = 0;
    end

    // Reset state
    step(); step();
    rst = 1'b0;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid", 32'(inport_valid), 32'h0);
    chk("rst_data", 32'(inport_data), 32'h0);

    // Single 3-byte message on req0
    push(0, 8'h41, 0); push(0, 8'h42, 0); push(0, 8'h43, 1);
    b = log_req.size(); c0 = cyc;
    step();
    chk("t1_grant", 32'(grant), 32'b0001);
    step(); step(); step();
    chk("t1_release", 32'(grant), 32'h0);
    chk("t1_count", 32'(log_req.size() - b), 32'd3);
    if (log_req.size() - b == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t1_data", 32'(log_dat[b+i]), 32'(8'h41 + i));
        chk("t1_cycle", 32'(log_cyc[b+i] - c0), 32'(1 + i));
      end
    end

    // req1 and req3 together with rr=0
    rst = 1'b1; step(); rst = 1'b0;
    push(1, 8'hB1, 0); push(1, 8'hB2, 1); push(3, 8'hC1, 0); push(3, 8'hC2, 1);
    b = log_req.size(); c0 = cyc;
    for (int i = 0; i < 8; i++) step();
    chk("t2_count", 32'(log_req.size() - b), 32'd4);
    if (log_req.size() - b == 4) begin
      chk("t2_req0", 32'(log_req[b]), 32'd1);
      chk("t2_req1", 32'(log_req[b+1]), 32'd1);
      chk("t2_req2", 32'(log_req[b+2]), 32'd3);
      chk("t2_req3", 32'(log_req[b+3]), 32'd3);
      chk("t2_dat", 32'(log_dat[b+2]), 32'hC1);
      chk("t2_gap", 32'(log_cyc[b+2] - log_cyc[b+1]), 32'd2);
    end

    // Fairness: all requesters valid, no last
    ord[0] = 0; ord[1] = 1; ord[2] = 2; ord[3] = 3; ord[4] = 0;
    for (int k = 0; k < 32; k++) push(0, k, 0);
    for (int n = 1; n < N; n++) for (int k = 0; k < 16; k++) push(n, 16*n + k, 0);
    b = log_req.size();
    for (int i = 0; i < 90; i++) step();
    chk("t3_count", 32'(log_req.size() - b), 32'd80);
    if (log_req.size() - b == 80) begin
      for (int i = 0; i < 80; i++) chk("t3_order", 32'(log_req[b+i]), 32'(ord[i/16]));
    end

    // Idle release after a partial message on req2
    push(2, 8'h77, 0);
    step();
    chk("t4_grant", 32'(grant), 32'b0100);
    step();
    for (int i = 0; i < IC - 1; i++) begin
      step();
      chk("t4_hold", 32'(grant), 32'b0100);
    end
    step();
    chk("t4_release", 32'(grant), 32'h0);
    push(0, 8'h01, 1); push(3, 8'h02, 1);
    step();
    chk("t4_rr", 32'(grant), 32'b1000);
    for (int i = 0; i < 6; i++) step();

    // Core back-pressure
    acc_pct = 0;
    push(0, 8'hA5, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_data", 32'(inport_data), 32'hA5);
      chk("t5_accept", 32'(req_accept), 32'h0);
      chk("t5_grant", 32'(grant), 32'b0001);
    end
    acc_pct = 100;
    b = log_req.size();
    step();
    chk("t5_count", 32'(log_req.size() - b), 32'd1);
    if (log_req.size() - b == 1) chk("t5_byte", 32'(log_dat[b]), 32'hA5);
    chk("t5_release", 32'(grant), 32'h0);

    // Reset mid-burst
    for (int k = 0; k < 10; k++) push(1, 8'h60 + k, 0);
    step(); step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6_grant", 32'(grant), 32'h0);
    chk("t6_valid", 32'(inport_valid), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    flush();
    b = log_req.size();
    for (int i = 0; i < 3; i++) step();
    chk("t6_no_xfer", 32'(log_req.size() - b), 32'd0);

    // Randomized traffic
    gap_pct = 30;
    acc_pct = 70;
    for (int t = 0; t < 3000; t++) begin
      for (int n = 0; n < N; n++) begin
        if ((pt[n] - ph[n] < 4) && ($urandom_range(7) == 0)) begin
          int len;
          len = int'($urandom_range(6, 1));
          for (int k = 0; k < len; k++) push(n, int'($urandom_range(255)), (k == len - 1) && ($urandom_range(3) != 0));
        end
      end
      step();
    end
    gap_pct = 0;
    acc_pct = 100;
    for (int i = 0; i < 120; i++) step();

`ifdef USB_ARB_STATS_EN
    for (int s = 0; s < 8; s++) begin
      stat_sel = 3'(s);
      step();
      chk("stat_sel", 32'(stat_count), (s < N) ? 32'(mcnt[s]) : 32'h0);
    end
    flush();
    pushed = 0;
    while (pushed < 70000 || ph[1] < pt[1]) begin
      while (pushed < 70000 && pt[1] - ph[1] < 32) begin
        push(1, pushed, 0);
        pushed++;
      end
      step();
    end
    for (int i = 0; i < 12; i++) step();
    stat_sel = 3'd1;
    step();
    chk("stat_sat", 32'(stat_count), 32'hFFFF);
`else
    pushed = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
